// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
// LFSR constants are only consumed when DMEM_RAND_STALL_EN is defined.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response valid-ready channels between the MEM stage and the data memory.
interface dmem_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and right-alignment plus extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] shifted;

  // Stores replicate the narrow datum across all lanes; byte_en picks the live ones
  always_comb begin
    byte_en  = 4'b0000;
    wword    = wdata;
    misalign = 1'b0;
    shifted  = rword >> {addr_lo, 3'b000};
    rdata    = shifted;
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        rdata   = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byte_en  = 4'b0011 << {addr_lo[1], 1'b0};
        wword    = {2{wdata[15:0]}};
        rdata    = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        misalign = addr_lo[0];
      end
      SZ_WORD: begin
        byte_en  = 4'b1111;
        misalign = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Handshaked data memory with programmable latency, lane alignment and error flags.
// Define DMEM_RAND_STALL_EN to add 0-3 LFSR-driven extra wait cycles per request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n, load_cnt;
  logic        started;
  logic        cap_we, cap_unsigned;
  logic [31:0] cap_addr, cap_wdata;
  logic [1:0]  cap_size;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, enter_resp;
  logic        a_we, a_unsigned;
  logic [31:0] a_addr, a_wdata, offset;
  logic [1:0]  a_size;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]  byte_en;
  logic [31:0] wword, load_data;
  logic        misalign, out_of_range, access_err;

  assign bus.req_ready = started && (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef DMEM_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr <= LFSR_SEED;
    else        lfsr <= lfsr_next(lfsr);
  end

  assign load_cnt = 5'(LATENCY - 1) + {3'b000, lfsr[1:0]};
`else
  assign load_cnt = 5'(LATENCY - 1);
`endif

  // With no wait cycles the access happens on the accept edge, so use live request fields
  assign a_we       = (state == IDLE) ? bus.req_we       : cap_we;
  assign a_addr     = (state == IDLE) ? bus.req_addr     : cap_addr;
  assign a_wdata    = (state == IDLE) ? bus.req_wdata    : cap_wdata;
  assign a_size     = (state == IDLE) ? bus.req_size     : cap_size;
  assign a_unsigned = (state == IDLE) ? bus.req_unsigned : cap_unsigned;

  assign offset       = a_addr - BASE_ADDR;
  assign mem_idx      = offset[IDX_W+1:2];
  assign out_of_range = (a_addr < BASE_ADDR) || ({1'b0, offset} >= 33'(DEPTH_WORDS) * 33'd4);
  assign access_err   = misalign || out_of_range || (a_size == 2'b11);

  dmem_lane_align u_align (
    .addr_lo     (a_addr[1:0]),
    .size        (a_size),
    .is_unsigned (a_unsigned),
    .wdata       (a_wdata),
    .rword       (mem[mem_idx]),
    .byte_en     (byte_en),
    .wword       (wword),
    .rdata       (load_data),
    .misalign    (misalign)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_n   = load_cnt;
        state_n = (load_cnt == 5'd0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 5'd1;
        if (cnt <= 5'd1) state_n = RESP;
      end
      RESP: if (bus.rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_resp = (state_n == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      started      <= 1'b0;
      cap_we       <= 1'b0;
      cap_unsigned <= 1'b0;
      cap_addr     <= 32'h0;
      cap_wdata    <= 32'h0;
      cap_size     <= SZ_BYTE;
      rsp_rdata_q  <= 32'h0;
      rsp_err_q    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      started <= 1'b1;
      if (accept) begin
        cap_we       <= bus.req_we;
        cap_unsigned <= bus.req_unsigned;
        cap_addr     <= bus.req_addr;
        cap_wdata    <= bus.req_wdata;
        cap_size     <= bus.req_size;
      end
      if (enter_resp) begin
        rsp_err_q   <= access_err;
        rsp_rdata_q <= (access_err || a_we) ? 32'h0 : load_data;
      end
    end
  end

  // Storage is not reset; a store lands only on the edge that enters RESP
  always_ff @(posedge clk) begin
    if (enter_resp && a_we && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[mem_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (LATENCY=2, 1024 words, base 0).
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dmem_if bus ();

  dmem_responder #(
    .DEPTH_WORDS (1024),
    .LATENCY     (2),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction with rsp_ready held high; lat counts edges from accept to rsp_valid
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns,
                                output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_valid    = 1'b1;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    tick();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;

    tick();
    tick();
    check_output("reset_req_ready", 32'(bus.req_ready), 32'h0);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check_output("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    reset = 1'b1;
    #1;
    check_output("release_req_ready_before_edge", 32'(bus.req_ready), 32'h0);
    tick();
    check_output("release_req_ready_after_edge", 32'(bus.req_ready), 32'h1);

    $display("[TB] word store/load");
    apply_stimulus(1'b1, 32'h10, 32'hDEADBEEF, SZ_WORD, 1'b0, rd, er, lat);
    check_output("sw_latency", 32'(lat), 32'd2);
    check_output("sw_err", 32'(er), 32'h0);
    check_output("sw_rdata", rd, 32'h0);
    check_output("sw_req_ready_after", 32'(bus.req_ready), 32'h1);
    apply_stimulus(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("lw_latency", 32'(lat), 32'd2);
    check_output("lw_rdata", rd, 32'hDEADBEEF);
    check_output("lw_err", 32'(er), 32'h0);

    $display("[TB] byte lanes and extension");
    apply_stimulus(1'b1, 32'h13, 32'h00000080, SZ_BYTE, 1'b0, rd, er, lat);
    check_output("sb_err", 32'(er), 32'h0);
    apply_stimulus(1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b0, rd, er, lat);
    check_output("lb_signed", rd, 32'hFFFFFF80);
    apply_stimulus(1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b1, rd, er, lat);
    check_output("lbu_unsigned", rd, 32'h00000080);
    apply_stimulus(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("lw_after_sb", rd, 32'h80ADBEEF);
    apply_stimulus(1'b0, 32'h11, 32'h0, SZ_BYTE, 1'b1, rd, er, lat);
    check_output("lbu_lane1", rd, 32'h000000BE);

    $display("[TB] misalignment and illegal size");
    apply_stimulus(1'b0, 32'h11, 32'h0, SZ_HALF, 1'b0, rd, er, lat);
    check_output("lh_misalign_err", 32'(er), 32'h1);
    check_output("lh_misalign_rdata", rd, 32'h0);
    apply_stimulus(1'b1, 32'h12, 32'h11111111, SZ_WORD, 1'b0, rd, er, lat);
    check_output("sw_misalign_err", 32'(er), 32'h1);
    apply_stimulus(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("lw_after_suppressed", rd, 32'h80ADBEEF);
    apply_stimulus(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, rd, er, lat);
    check_output("illegal_size_err", 32'(er), 32'h1);
    check_output("illegal_size_rdata", rd, 32'h0);

    $display("[TB] half lanes");
    apply_stimulus(1'b1, 32'h12, 32'h0000CAFE, SZ_HALF, 1'b0, rd, er, lat);
    check_output("sh_err", 32'(er), 32'h0);
    apply_stimulus(1'b0, 32'h10, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("lw_after_sh", rd, 32'hCAFEBEEF);
    apply_stimulus(1'b0, 32'h12, 32'h0, SZ_HALF, 1'b0, rd, er, lat);
    check_output("lh_signed", rd, 32'hFFFFCAFE);
    apply_stimulus(1'b0, 32'h10, 32'h0, SZ_HALF, 1'b1, rd, er, lat);
    check_output("lhu_unsigned", rd, 32'h0000BEEF);

    $display("[TB] range boundary");
    apply_stimulus(1'b0, 32'h1000, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("oor_err", 32'(er), 32'h1);
    check_output("oor_rdata", rd, 32'h0);
    apply_stimulus(1'b1, 32'hFFC, 32'h0BADF00D, SZ_WORD, 1'b0, rd, er, lat);
    check_output("last_word_store_err", 32'(er), 32'h0);
    apply_stimulus(1'b0, 32'hFFC, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("last_word_load", rd, 32'h0BADF00D);
    check_output("last_word_latency", 32'(lat), 32'd2);

    $display("[TB] response backpressure");
    bus.rsp_ready    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_size     = SZ_WORD;
    bus.req_unsigned = 1'b0;
    bus.req_valid    = 1'b1;
    tick();
    bus.req_addr = 32'h12;
    bus.req_size = SZ_HALF;
    tick();
    check_output("stall_rsp_valid_rise", 32'(bus.rsp_valid), 32'h1);
    check_output("stall_rdata", bus.rsp_rdata, 32'hCAFEBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("stall_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check_output("stall_hold_rdata", bus.rsp_rdata, 32'hCAFEBEEF);
      check_output("stall_hold_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check_output("stall_release_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("stall_release_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 1'b0;
    check_output("held_req_accepted", 32'(bus.req_ready), 32'h0);
    tick();
    check_output("held_req_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check_output("held_req_rdata", bus.rsp_rdata, 32'hFFFFCAFE);
    tick();

    $display("[TB] reset during wait");
    apply_stimulus(1'b1, 32'h20, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h12345678;
    bus.req_size  = SZ_WORD;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    reset = 1'b0;
    #1;
    check_output("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check_output("abort_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    tick();
    check_output("abort_held_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    reset = 1'b1;
    tick();
    apply_stimulus(1'b0, 32'h20, 32'h0, SZ_WORD, 1'b0, rd, er, lat);
    check_output("abort_no_commit", rd, 32'h0);
    check_output("abort_load_err", 32'(er), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
